// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion blocks.
//   bcd_digits()     : number of decimal digits used for a given binary width
//   DIGIT_MAX        : largest legal BCD digit value
//   bcd2bin_state_t  : state encoding of the sequential BCD-to-binary FSM
// ----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_t;

  // Integer form of ceil(bin_width * log10(2)), with log10(2) taken as 0.3.
  // Gives 3 digits for both 8-bit and 10-bit results.
  function automatic int bcd_digits(int bin_width);
    return (bin_width * 3 + 9) / 10;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// ----------------------------------------------------------------------------
// bcd_digit_mac
// One decimal multiply-accumulate step: acc_out = acc_in*10 + digit.
// Purely combinational so that a parallel converter can chain copies of it.
//   acc_in    in  ACC_WIDTH  running binary value
//   digit     in  4          next BCD digit (most significant first)
//   acc_out   out ACC_WIDTH  acc_in*10 + digit, truncated to ACC_WIDTH
//   digit_bad out 1          digit is not a legal BCD value (>9)
// ----------------------------------------------------------------------------
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int ACC_WIDTH = 14
) (
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic [3:0]           digit,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 digit_bad
);

  // x*10 as (x<<3)+(x<<1): two adders, no multiplier.
  always_comb begin
    acc_out   = (acc_in << 3) + (acc_in << 1) + ACC_WIDTH'(digit);
    digit_bad = (digit > 4'(DIGIT_MAX));
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// ----------------------------------------------------------------------------
// bcd2bin_seq
// Sequential BCD-to-binary converter. Accepts a packed BCD word on a
// ready/start handshake, folds in one digit per clock (most significant
// first) and presents the binary result with a one-cycle valid pulse.
//   clk    in  1          rising-edge clock
//   rst    in  1          synchronous active-high reset
//   start  in  1          conversion request, taken only while ready=1
//   bcd    in  BCD_WIDTH  packed BCD, digit 0 (ones) in bcd[3:0]
//   ready  out 1          idle, can accept start
//   valid  out 1          one-cycle pulse, bin/err hold a new result
//   bin    out BIN_WIDTH  binary result, held until the next result
//   err    out 1          last result had a digit >9 or exceeded 2**BIN_WIDTH-1
// ----------------------------------------------------------------------------
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 10,
  parameter int BCD_DIGITS = bcd_digits(BIN_WIDTH),
  parameter int BCD_WIDTH  = 4 * BCD_DIGITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BCD_WIDTH-1:0] bcd,
  output logic                 ready,
  output logic                 valid,
  output logic [BIN_WIDTH-1:0] bin,
  output logic                 err
);

  // Four guard bits: a legal accumulator (<2**BIN_WIDTH) times 10 plus 15
  // always fits, so the first overflow is always visible in the guard bits.
  localparam int ACC_W = BIN_WIDTH + 4;
  localparam int CNT_W = $clog2(BCD_DIGITS + 1);

  bcd2bin_state_t r_state;
  bcd2bin_state_t w_state_next;

  logic [BCD_WIDTH-1:0] r_shift;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sticky;
  logic [BIN_WIDTH-1:0] r_bin;
  logic                 r_err;

  logic [3:0]           w_top_digit;
  logic [ACC_W-1:0]     w_acc_next;
  logic                 w_digit_bad;
  logic                 w_overflow;
  logic                 w_sticky_next;
  logic                 w_last;

  assign w_top_digit   = r_shift[BCD_WIDTH-1 -: 4];
  assign w_overflow    = |w_acc_next[ACC_W-1:BIN_WIDTH];
  assign w_sticky_next = r_sticky | w_digit_bad | w_overflow;
  assign w_last        = (r_cnt == CNT_W'(BCD_DIGITS - 1));

  bcd_digit_mac #(
    .ACC_WIDTH (ACC_W)
  ) u_mac (
    .acc_in    (r_acc),
    .digit     (w_top_digit),
    .acc_out   (w_acc_next),
    .digit_bad (w_digit_bad)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: the default assignment on entry keeps every path assigned, so no
  // latch is inferred for w_state_next.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_next = CONV;
      CONV:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (state only, no path from start or bcd)
  // --------------------------------------------------------------------------
  always_comb begin
    ready = (r_state == IDLE);
    valid = (r_state == DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath: digit shift register, accumulator, counter, result registers
  // --------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not just the visible outputs, so
  // an aborted conversion leaves no stale digits or error state behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_bin    <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift  <= bcd;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
          end
        end
        CONV: begin
          r_acc    <= w_acc_next;
          r_shift  <= r_shift << 4;
          r_cnt    <= r_cnt + CNT_W'(1);
          r_sticky <= w_sticky_next;
          // Last digit: publish the result directly from the MAC output so
          // bin/err update on the same edge that enters DONE.
          if (w_last) begin
            r_bin <= w_acc_next[BIN_WIDTH-1:0];
            r_err <= w_sticky_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bin = r_bin;
  assign err = r_err;

endmodule
